// File: rtl/gcd_lcm_ctrl.sv
// gcd_lcm_ctrl
// Memory-mapped sequencer for the GCD/LCM coprocessor datapath. Holds the
// operand, control, status and result registers on the data-memory bus and
// runs an iterative subtract (GCD) or add (LCM) loop, one step per cycle,
// after a start command. Completion raises a sticky done flag and DoneIrq.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high; clears all state
//   WE         register write strobe, sampled at posedge clk
//   Addr       byte address: 0x00 OPA, 0x04 OPB, 0x08 CTRL, 0x0C STATUS,
//              0x10 RESULT; other addresses read 0 and ignore writes
//   WriteData  write data
//   ReadData   combinational read of the register selected by Addr
//   DoneIrq    level interrupt, mirrors STATUS.done
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | waiting for a start command; busy=0
// S_RUN  | one subtract/add step per cycle until a terminal condition

module gcd_lcm_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             WE,
    input  logic [4:0]       Addr,
    input  logic [WIDTH-1:0] WriteData,
    output logic [WIDTH-1:0] ReadData,
    output logic             DoneIrq
);

    localparam logic [4:0] ADDR_OPA    = 5'h00;
    localparam logic [4:0] ADDR_OPB    = 5'h04;
    localparam logic [4:0] ADDR_CTRL   = 5'h08;
    localparam logic [4:0] ADDR_STATUS = 5'h0C;
    localparam logic [4:0] ADDR_RESULT = 5'h10;

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] opa, opb, result, result_nxt;
    logic [WIDTH-1:0] x, x_nxt, y, y_nxt;
    logic [WIDTH-1:0] inc_a, inc_a_nxt, inc_b, inc_b_nxt;
    logic             op_lcm, op_lcm_nxt;
    logic             done, done_nxt, ovf, ovf_nxt, err, err_nxt;

    logic             wr_opa, wr_opb, wr_ctrl, wr_status;
    logic             cmd_start, cmd_abort;
    logic [WIDTH:0]   sum_x, sum_y;

    assign wr_opa    = WE && (Addr == ADDR_OPA);
    assign wr_opb    = WE && (Addr == ADDR_OPB);
    assign wr_ctrl   = WE && (Addr == ADDR_CTRL);
    assign wr_status = WE && (Addr == ADDR_STATUS);
    assign cmd_start = wr_ctrl && WriteData[0];
    assign cmd_abort = wr_ctrl && WriteData[2];

    // One extra bit holds the carry-out that flags LCM overflow.
    assign sum_x = {1'b0, x} + {1'b0, inc_a};
    assign sum_y = {1'b0, y} + {1'b0, inc_b};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= S_IDLE;
            opa    <= '0;
            opb    <= '0;
            result <= '0;
            x      <= '0;
            y      <= '0;
            inc_a  <= '0;
            inc_b  <= '0;
            op_lcm <= 1'b0;
            done   <= 1'b0;
            ovf    <= 1'b0;
            err    <= 1'b0;
        end else begin
            state  <= state_nxt;
            result <= result_nxt;
            x      <= x_nxt;
            y      <= y_nxt;
            inc_a  <= inc_a_nxt;
            inc_b  <= inc_b_nxt;
            op_lcm <= op_lcm_nxt;
            done   <= done_nxt;
            ovf    <= ovf_nxt;
            err    <= err_nxt;
            if (wr_opa) opa <= WriteData;
            if (wr_opb) opb <= WriteData;
        end
    end

    always_comb begin
        state_nxt  = state;
        result_nxt = result;
        x_nxt      = x;
        y_nxt      = y;
        inc_a_nxt  = inc_a;
        inc_b_nxt  = inc_b;
        op_lcm_nxt = op_lcm;
        done_nxt   = done;
        ovf_nxt    = ovf;
        err_nxt    = err;

        // W1C first, so any flag set below on the same edge takes priority.
        if (wr_status) begin
            done_nxt = done & ~WriteData[1];
            ovf_nxt  = ovf  & ~WriteData[2];
            err_nxt  = err  & ~WriteData[3];
        end

        case (state)
            S_IDLE: begin
                if (cmd_start) begin
                    x_nxt      = opa;
                    y_nxt      = opb;
                    inc_a_nxt  = opa;
                    inc_b_nxt  = opb;
                    op_lcm_nxt = WriteData[1];
                    done_nxt   = 1'b0;
                    ovf_nxt    = 1'b0;
                    err_nxt    = 1'b0;
                    state_nxt  = S_RUN;
                end
            end
            S_RUN: begin
                if (cmd_abort) begin
                    // Abort beats both start and a terminating step.
                    state_nxt = S_IDLE;
                end else begin
                    if (cmd_start) err_nxt = 1'b1;
                    if ((x == '0) || (y == '0)) begin
                        result_nxt = op_lcm ? '0 : (x | y);
                        done_nxt   = 1'b1;
                        state_nxt  = S_IDLE;
                    end else if (x == y) begin
                        result_nxt = x;
                        done_nxt   = 1'b1;
                        state_nxt  = S_IDLE;
                    end else if (!op_lcm) begin
                        if (x > y) x_nxt = x - y;
                        else       y_nxt = y - x;
                    end else if (x < y) begin
                        if (sum_x[WIDTH]) begin
                            result_nxt = '0;
                            ovf_nxt    = 1'b1;
                            done_nxt   = 1'b1;
                            state_nxt  = S_IDLE;
                        end else begin
                            x_nxt = sum_x[WIDTH-1:0];
                        end
                    end else begin
                        if (sum_y[WIDTH]) begin
                            result_nxt = '0;
                            ovf_nxt    = 1'b1;
                            done_nxt   = 1'b1;
                            state_nxt  = S_IDLE;
                        end else begin
                            y_nxt = sum_y[WIDTH-1:0];
                        end
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        ReadData = '0;
        case (Addr)
            ADDR_OPA:    ReadData = opa;
            ADDR_OPB:    ReadData = opb;
            ADDR_STATUS: ReadData = {{(WIDTH-4){1'b0}}, err, ovf, done, (state == S_RUN)};
            ADDR_RESULT: ReadData = result;
            default:     ReadData = '0;
        endcase
    end

    assign DoneIrq = done;

endmodule

// File: tb/tb_gcd_lcm_ctrl.sv
// Self-checking bench for gcd_lcm_ctrl: directed boundary cases plus random
// GCD/LCM runs compared against an arithmetic reference (Euclid's algorithm,
// lcm = a*b/gcd) including the expected cycle count of each run.

module tb_gcd_lcm_ctrl;

    localparam logic [4:0] A_OPA = 5'h00, A_OPB = 5'h04, A_CTRL = 5'h08,
                           A_STAT = 5'h0C, A_RES = 5'h10;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        WE = 1'b0;
    logic [4:0]  Addr = 5'h00;
    logic [31:0] WriteData = '0;
    logic [31:0] ReadData;
    logic        DoneIrq;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] last_result = '0;

    gcd_lcm_ctrl #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .WE(WE), .Addr(Addr),
        .WriteData(WriteData), .ReadData(ReadData), .DoneIrq(DoneIrq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        WE = 1'b1; Addr = a; WriteData = d;
        @(posedge clk);
        #1;
        WE = 1'b0;
    endtask

    task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
        Addr = a;
        #1;
        d = ReadData;
    endtask

    // Reference model: plain arithmetic.
    function automatic longint unsigned m_gcd(input longint unsigned a, input longint unsigned b);
        longint unsigned t;
        while (b != 0) begin t = a % b; a = b; b = t; end
        return a;
    endfunction

    // Subtractive GCD takes (sum of Euclid quotients) - 1 steps.
    function automatic longint unsigned m_gcd_steps(input longint unsigned a, input longint unsigned b);
        longint unsigned s = 0, t;
        if (a == 0 || b == 0) return 0;
        while (b != 0) begin s += a / b; t = a % b; a = b; b = t; end
        return s - 1;
    endfunction

    function automatic longint unsigned m_lcm(input longint unsigned a, input longint unsigned b);
        if (a == 0 || b == 0) return 0;
        return (a * b) / m_gcd(a, b);
    endfunction

    // Additive LCM walks each operand's multiples up to the lcm.
    function automatic longint unsigned m_lcm_steps(input longint unsigned a, input longint unsigned b);
        longint unsigned l;
        if (a == 0 || b == 0) return 0;
        l = m_lcm(a, b);
        return (l / a - 1) + (l / b - 1);
    endfunction

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit lcm, input string tag);
        logic [31:0] st, rd;
        longint unsigned exp_res, exp_k;
        int n;
        exp_res = lcm ? m_lcm(a, b) : m_gcd(a, b);
        exp_k   = lcm ? m_lcm_steps(a, b) : m_gcd_steps(a, b);
        bus_write(A_OPA, a);
        bus_write(A_OPB, b);
        bus_write(A_CTRL, {30'd0, lcm, 1'b1});
        bus_read(A_STAT, st);
        chk({tag, " busy_after_start"}, st, 32'h1);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
            bus_read(A_STAT, st);
        end while (st[0] && n < 20000);
        chk({tag, " latency"}, n, 32'(exp_k + 1));
        chk({tag, " status"}, st, 32'h2);
        bus_read(A_RES, rd);
        chk({tag, " result"}, rd, 32'(exp_res));
        chk({tag, " irq"}, {31'd0, DoneIrq}, 32'h1);
        last_result = 32'(exp_res);
        bus_write(A_STAT, 32'hE);
    endtask

    initial begin
        logic [31:0] rd, a, b;
        bit lcm;
        int n;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        bus_read(A_OPA, rd);  chk("rst opa", rd, 32'h0);
        bus_read(A_OPB, rd);  chk("rst opb", rd, 32'h0);
        bus_read(A_STAT, rd); chk("rst status", rd, 32'h0);
        bus_read(A_RES, rd);  chk("rst result", rd, 32'h0);
        chk("rst irq", {31'd0, DoneIrq}, 32'h0);

        bus_write(A_OPA, 32'hDEADBEEF);
        bus_write(5'h14, 32'h12345678);
        bus_read(A_OPA, rd);  chk("opa rw", rd, 32'hDEADBEEF);
        bus_read(5'h14, rd);  chk("unmapped read", rd, 32'h0);
        bus_read(A_CTRL, rd); chk("ctrl reads 0", rd, 32'h0);

        // GCD(12,8): busy through E2, done after E3, then W1C clears done.
        bus_write(A_OPA, 32'd12);
        bus_write(A_OPB, 32'd8);
        bus_write(A_CTRL, 32'h1);
        bus_read(A_STAT, rd); chk("g12_8 busy E0", rd, 32'h1);
        @(posedge clk); #1; bus_read(A_STAT, rd); chk("g12_8 busy E1", rd, 32'h1);
        @(posedge clk); #1; bus_read(A_STAT, rd); chk("g12_8 busy E2", rd, 32'h1);
        @(posedge clk); #1; bus_read(A_STAT, rd); chk("g12_8 done E3", rd, 32'h2);
        bus_read(A_RES, rd); chk("g12_8 result", rd, 32'd4);
        chk("g12_8 irq", {31'd0, DoneIrq}, 32'h1);
        bus_write(A_STAT, 32'h2);
        bus_read(A_STAT, rd); chk("w1c done", rd, 32'h0);
        chk("w1c irq", {31'd0, DoneIrq}, 32'h0);

        run_op(32'd4, 32'd6, 1'b1, "lcm4_6");
        run_op(32'd0, 32'd9, 1'b0, "gcd0_9");
        run_op(32'd0, 32'd0, 1'b0, "gcd0_0");
        run_op(32'd7, 32'd0, 1'b1, "lcm7_0");
        run_op(32'd5, 32'd5, 1'b0, "gcd5_5");

        // Done set and W1C on the same edge: set wins.
        bus_write(A_OPA, 32'd5);
        bus_write(A_OPB, 32'd5);
        bus_write(A_CTRL, 32'h1);
        bus_write(A_STAT, 32'h2);
        bus_read(A_STAT, rd); chk("set beats w1c", rd, 32'h2);
        bus_write(A_STAT, 32'hE);
        last_result = 32'd5;

        // LCM overflow: 2*0xFFFFFFFE carries on the very first add.
        bus_write(A_OPA, 32'hFFFFFFFF);
        bus_write(A_OPB, 32'hFFFFFFFE);
        bus_write(A_CTRL, 32'h3);
        n = 0;
        do begin
            @(posedge clk); #1; n++;
            bus_read(A_STAT, rd);
        end while (rd[0] && n < 50);
        chk("ovf latency", n, 32'd1);
        chk("ovf status", rd, 32'h6);
        bus_read(A_RES, rd); chk("ovf result", rd, 32'h0);
        bus_write(A_STAT, 32'hE);
        last_result = 32'h0;

        // Long GCD: restart mid-run flags error, abort stops without done.
        run_op(32'd21, 32'd14, 1'b0, "gcd21_14");
        bus_write(A_OPA, 32'hFFFFFFFF);
        bus_write(A_OPB, 32'd1);
        bus_write(A_CTRL, 32'h1);
        repeat (5) @(posedge clk);
        bus_write(A_CTRL, 32'h1);
        bus_read(A_STAT, rd); chk("restart err+busy", rd, 32'h9);
        repeat (3) @(posedge clk);
        bus_read(A_STAT, rd); chk("still running", {31'd0, rd[0]}, 32'h1);
        bus_write(A_CTRL, 32'h5);
        bus_read(A_STAT, rd);
        chk("abort busy", {31'd0, rd[0]}, 32'h0);
        chk("abort done", {31'd0, rd[1]}, 32'h0);
        bus_read(A_RES, rd); chk("abort result", rd, last_result);
        bus_write(A_STAT, 32'hE);

        // Reset pulse mid-run.
        bus_write(A_CTRL, 32'h1);
        repeat (4) @(posedge clk);
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        #1;
        bus_read(A_STAT, rd); chk("midrst status", rd, 32'h0);
        bus_read(A_RES, rd);  chk("midrst result", rd, 32'h0);
        bus_read(A_OPA, rd);  chk("midrst opa", rd, 32'h0);
        run_op(32'd12, 32'd8, 1'b0, "post_rst gcd");

        for (int i = 0; i < 24; i++) begin
            a = $urandom_range(0, 60);
            b = $urandom_range(1, 60);
            if ($urandom_range(0, 7) == 0) a = 0;
            lcm = 1'($urandom_range(0, 1));
            run_op(a, b, lcm, $sformatf("rnd%0d %s(%0d,%0d)", i, lcm ? "lcm" : "gcd", a, b));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/gcd_lcm_ctrl.md
# gcd_lcm_ctrl

Memory-mapped controller that sequences the GCD/LCM coprocessor datapath for the RISC-V core. It holds the operand, control, status and result registers on the data-memory bus. On a start command it runs an iterative subtract/add loop to completion, then raises a sticky done flag and interrupt. It replaces the fixed-delay Start-count scheme with a real busy/done handshake.

## Interface
- WIDTH, 32: operand/result width in bits.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high; clears all state.
- WE  input  1  register write strobe, sampled at posedge clk.
- Addr  input  5  byte address: 0x00 OPA, 0x04 OPB, 0x08 CTRL, 0x0C STATUS, 0x10 RESULT; others read 0, writes ignored.
- WriteData  input  WIDTH  write data.
- ReadData  output  WIDTH  combinational read of the register selected by Addr.
- DoneIrq  output  1  level interrupt, equals STATUS.done.

## Operation
- OPA, OPB: R/W at any time; the datapath captures them into working registers x, y only on start.
- CTRL (write-only, reads 0): bit0 start, bit1 op (0 = GCD, 1 = LCM), bit2 abort.
- STATUS (read): bit0 busy, bit1 done, bit2 overflow, bit3 error. Write is W1C for bits 1–3; bit0 is read-only.
- RESULT: read-only, holds the last completed result.
- States: IDLE, RUN.
- IDLE + CTRL write with start=1:
  - x←OPA, y←OPB, op latched.
  - done, overflow and error cleared.
  - Go to RUN; busy=1.
  - The abort bit is ignored in IDLE.
- RUN, one step per cycle, checked in this priority:
  1. Either x or y is zero: RESULT←(GCD ? x|y : 0), done=1, go to IDLE.
  2. x==y: RESULT←x, done=1, go to IDLE.
  3. GCD: if x>y then x←x−y, else y←y−x.
  4. LCM: if x<y then x←x+OPA_latched, else y←y+OPB_latched. The increments are the operand values captured at start.
  5. LCM add carry-out: RESULT←0, overflow=1, done=1, go to IDLE.
- RUN + CTRL write with abort=1:
  - Go to IDLE at that edge; busy=0.
  - done, overflow and RESULT are unchanged.
  - abort beats start in the same write.
- RUN + CTRL write with start=1 and abort=0: command ignored, error=1, computation continues.
- W1C of done on the same edge that sets done: set wins.
- Unsigned arithmetic throughout; GCD subtraction never underflows because the larger value is always reduced.

## Timing
- Reset values:
  - state=IDLE.
  - OPA, OPB, RESULT, x, y = 0.
  - STATUS=0; ReadData reflects registers (0 after reset); DoneIrq=0.
- Start accepted at edge E0: busy reads 1 after E0.
- Each RUN step takes one edge. Termination at edge E0+k+1, where k is the number of subtract/add steps.
- At the termination edge, busy falls and done/RESULT update together.
- Equal or zero operands complete at E0+1.
- ReadData is combinational. A read in the cycle after the termination edge sees the final STATUS/RESULT.
- Reset asserted mid-RUN: immediate return to IDLE, all registers cleared, no done.

## Test plan
- GCD: OPA=12, OPB=8, start op=0 at E0 -> busy 1 for E0..E2, done=1 and RESULT=4 after E3, DoneIrq=1; W1C 0x2 to STATUS -> done=0, DoneIrq=0.
- LCM: OPA=4, OPB=6, start op=1 -> RESULT=12 after E0+4, overflow=0.
- Boundaries:
  - GCD(0,9) -> 9 at E0+1.
  - GCD(0,0) -> 0.
  - LCM(7,0) -> 0.
  - GCD(5,5) -> 5 at E0+1.
- LCM(0xFFFFFFFF, 0xFFFFFFFE) -> overflow=1, RESULT=0, done=1, busy=0.
- GCD(0xFFFFFFFF,1):
  - Rewrite start mid-run -> error=1 and the run continues.
  - Abort -> busy=0 at that edge, done=0, RESULT keeps its prior value.
- Assert reset for one cycle mid-RUN -> all STATUS bits 0, RESULT=0, state IDLE; a new GCD(12,8) then completes with 4.
